// File: rtl/hazard_stall_if.sv
// hazard_stall_if: bundle between the pipeline and the hazard/stall controller.
//   master : pipeline side; drives the Decode/Execute instruction fields and haz_en,
//            and receives the stall, bubble, flush, busy and stall_count signals.
//   slave  : controller side (hazard_stall_ctrl).
// OPBITS, REGBITS and CNTBITS must match the parameters of the attached controller.
interface hazard_stall_if #(
   parameter int unsigned OPBITS  = 4,
   parameter int unsigned REGBITS = 4,
   parameter int unsigned CNTBITS = 16
);
   logic               haz_en;
   logic [OPBITS-1:0]  op_D;
   logic [REGBITS-1:0] rs_D;
   logic [REGBITS-1:0] rt_D;
   logic               valid_D;
   logic [OPBITS-1:0]  op_E;
   logic [REGBITS-1:0] rd_E;
   logic               valid_E;
   logic               stall_F;
   logic               stall_D;
   logic               bubble_E;
   logic               flush_D;
   logic               busy;
   logic [CNTBITS-1:0] stall_count;

   modport master (
      output haz_en, op_D, rs_D, rt_D, valid_D, op_E, rd_E, valid_E,
      input  stall_F, stall_D, bubble_E, flush_D, busy, stall_count
   );

   modport slave (
      input  haz_en, op_D, rs_D, rt_D, valid_D, op_E, rd_E, valid_E,
      output stall_F, stall_D, bubble_E, flush_D, busy, stall_count
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use hazard and control-transfer stall controller for the
// decode/execute boundary.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : hazard_stall_if.slave
//             in : haz_en, op_D, rs_D, rt_D, valid_D, op_E, rd_E, valid_E
//             out: stall_F (hold PC), stall_D (hold IF/ID), bubble_E (noop into ID/EX),
//                  flush_D (noop into IF/ID), busy (FSM not idle),
//                  stall_count (cycles with stall_F=1, wrapping)
// The first stall cycle of every event is decoded combinationally from the live inputs;
// the FSM only covers the remaining LOAD_BUBBLES-1 / CTRL_BUBBLES-1 cycles.
module hazard_stall_ctrl #(
   parameter int unsigned       OPBITS       = 4,
   parameter int unsigned       REGBITS      = 4,
   parameter logic [OPBITS-1:0] OP_LW        = 4'b0111,
   parameter logic [OPBITS-1:0] OP_SW        = 4'b0011,
   parameter logic [OPBITS-1:0] OP_BCOND    = 4'b0010,
   parameter logic [OPBITS-1:0] OP_JAL       = 4'b0110,
   parameter int unsigned       LOAD_BUBBLES = 1,
   parameter int unsigned       CTRL_BUBBLES = 2,
   parameter int unsigned       CNTBITS      = 16
) (
   input logic           clk,
   input logic           reset,
   hazard_stall_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StLoadWait, StCtrlWait} state_e;

   localparam logic [REGBITS-1:0] RegZero  = '0;
   localparam logic [3:0]         LoadInit = 4'(LOAD_BUBBLES - 1);
   localparam logic [3:0]         CtrlInit = 4'(CTRL_BUBBLES - 1);

   state_e             state_q;
   logic [3:0]         remaining_q;
   logic [CNTBITS-1:0] stall_count_q;

   logic load_use;
   logic ctrl_op;
   logic stall_f;
   logic stall_d;
   logic bubble_e;
   logic flush_d;

   // SW reads rt_D as store data, so rt_D is a hazard source for every opcode in D.
   // OP_SW therefore needs no special case.
   assign load_use = bus.valid_E && (bus.op_E == OP_LW) && bus.valid_D &&
                     (bus.rd_E != RegZero) &&
                     ((bus.rd_E == bus.rs_D) || (bus.rd_E == bus.rt_D));

   assign ctrl_op = bus.valid_D && ((bus.op_D == OP_BCOND) || (bus.op_D == OP_JAL));

   // Outputs are gated by reset so nothing leaks from live inputs while reset is held.
   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      bubble_e = 1'b0;
      flush_d  = 1'b0;
      if (bus.haz_en && !reset) begin
         unique case (state_q)
            StIdle: begin
               if (load_use) begin
                  stall_f  = 1'b1;
                  stall_d  = 1'b1;
                  bubble_e = 1'b1;
               end else if (ctrl_op && (CTRL_BUBBLES != 0)) begin
                  stall_f = 1'b1;
                  flush_d = 1'b1;
               end
            end
            StLoadWait: begin
               stall_f  = 1'b1;
               stall_d  = 1'b1;
               bubble_e = 1'b1;
            end
            StCtrlWait: begin
               stall_f = 1'b1;
               flush_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         remaining_q   <= 4'd0;
         stall_count_q <= '0;
      end else begin
         // stall_f is already zero when haz_en=0, so the count freezes with it.
         if (stall_f) begin
            stall_count_q <= stall_count_q + CNTBITS'(1);
         end

         if (!bus.haz_en) begin
            state_q     <= StIdle;
            remaining_q <= 4'd0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (load_use) begin
                     if (LOAD_BUBBLES > 1) begin
                        state_q     <= StLoadWait;
                        remaining_q <= LoadInit;
                     end
                  end else if (ctrl_op && (CTRL_BUBBLES > 1)) begin
                     state_q     <= StCtrlWait;
                     remaining_q <= CtrlInit;
                  end
               end
               StLoadWait, StCtrlWait: begin
                  remaining_q <= remaining_q - 4'd1;
                  if (remaining_q == 4'd1) begin
                     state_q <= StIdle;
                  end
               end
               default: begin
                  state_q     <= StIdle;
                  remaining_q <= 4'd0;
               end
            endcase
         end
      end
   end

   assign bus.stall_F     = stall_f;
   assign bus.stall_D     = stall_d;
   assign bus.bubble_E    = bubble_e;
   assign bus.flush_D     = flush_d;
   assign bus.busy        = (state_q != StIdle);
   assign bus.stall_count = stall_count_q;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised pipeline hazard and stall controller for the decode/execute boundary. It detects load-use hazards between the instruction in Execute and the instruction in Decode, and it inserts a configurable number of bubbles after control-transfer instructions (BCOND, JAL). It drives hold signals for the PC and the IF/ID register, plus bubble/flush controls for the pipeline registers, and keeps a running stall-cycle counter for performance monitoring.

## Interface
Parameters:
- OPBITS, 4, opcode width
- REGBITS, 4, register-address width
- OP_LW, 4'b0111, load opcode
- OP_SW, 4'b0011, store opcode
- OP_BCOND, 4'b0010, conditional-branch opcode
- OP_JAL, 4'b0110, jump-and-link opcode
- LOAD_BUBBLES, 1, stall cycles per load-use hazard (legal range 1..15)
- CTRL_BUBBLES, 2, stall cycles per control op (legal range 0..15)
- CNTBITS, 16, width of the stall counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- haz_en  in  1  1 = hazard logic active; 0 = all stall outputs forced 0, state frozen in IDLE
- op_D  in  OPBITS  opcode in Decode
- rs_D  in  REGBITS  source register 1 in Decode
- rt_D  in  REGBITS  source register 2 in Decode (store data for SW)
- valid_D  in  1  Decode slot holds a real instruction
- op_E  in  OPBITS  opcode in Execute
- rd_E  in  REGBITS  destination register in Execute
- valid_E  in  1  Execute slot holds a real instruction
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID
- bubble_E  out  1  load a noop into ID/EX at the next edge
- flush_D  out  1  load a noop into IF/ID at the next edge
- busy  out  1  FSM not in IDLE
- stall_count  out  CNTBITS  total cycles in which stall_F was 1; wraps

## Operation
- Load-use hazard (comb): valid_E & op_E==OP_LW & valid_D & rd_E!=0 & (rd_E==rs_D | rd_E==rt_D). This applies to every opcode in D, including SW. Register 0 is never a hazard source.
- Control op (comb): valid_D & (op_D==OP_BCOND | op_D==OP_JAL).
- FSM states: IDLE, LOAD_WAIT, CTRL_WAIT. A `remaining` counter is 4 bits wide.
- IDLE, load-use hazard:
  - Assert stall_F, stall_D and bubble_E this cycle.
  - If LOAD_BUBBLES>1, go to LOAD_WAIT with remaining=LOAD_BUBBLES-1.
- IDLE, control op with no load-use hazard and CTRL_BUBBLES>0:
  - Assert stall_F and flush_D this cycle. The control op advances to E.
  - If CTRL_BUBBLES>1, go to CTRL_WAIT with remaining=CTRL_BUBBLES-1.
- Priority: a load-use hazard wins over a control op. The control op is re-evaluated after the load stall ends.
- LOAD_WAIT: assert stall_F, stall_D and bubble_E. Decrement remaining. When remaining==1, the next state is IDLE. op_D/op_E are not re-evaluated.
- CTRL_WAIT: assert stall_F and flush_D. Decrement remaining. When remaining==1, the next state is IDLE. op_D is ignored.
- Bubble counts: total asserted cycles per event are exactly LOAD_BUBBLES or CTRL_BUBBLES. CTRL_BUBBLES=0 means a control op never stalls.
- IDLE with no event: all stall outputs are 0.
- busy = (state != IDLE).
- stall_count increments by 1 on each edge where stall_F==1. It wraps from 2^CNTBITS-1 to 0.
- haz_en=0: stall outputs are 0, the FSM is forced to IDLE on the next edge (including from a WAIT state), and stall_count does not increment.

## Timing
- Detection is combinational. Outputs assert in the same cycle the hazard is visible on the inputs. FSM and counters update on the rising edge of clk.
- Reset (asynchronous, immediate): state=IDLE, remaining=0, stall_count=0. While reset=1, stall_F, stall_D, bubble_E, flush_D and busy are all 0.
- Reset asserted mid-stall aborts the stall. After release, the FSM restarts from IDLE and re-evaluates the live inputs.
- With the default parameters:
  - Load-use: 1 stall cycle, then back-to-back issue resumes.
  - BCOND/JAL in D: stall_F/flush_D high for 2 consecutive cycles (D cycle and E cycle), then low.
- If op_E==OP_LW arrives while in CTRL_WAIT, it is not a hazard source. Upstream guarantees that a flushed slot carries valid=0.

## Test plan
- Reset: hold reset=1 with a LW hazard on the inputs. All outputs must be 0 and stall_count=0. Release reset; stall_F goes to 1 in the same cycle.
- Load-use: op_E=0111, rd_E=3, op_D=0000, rs_D=3, both valid. Response: exactly 1 cycle of stall_F=stall_D=bubble_E=1, and stall_count=1.
  - With rd_E=0: no stall.
  - With rt_D=3 and op_D=0011 (SW): 1 stall cycle.
- Control op: op_D=0010 (BCOND), op_E=0000. Response: stall_F=flush_D=1 for 2 cycles, busy=1 in the second cycle, then IDLE. Repeat with op_D=0110 (JAL): same response.
- Priority: op_E=0111, rd_E=5, op_D=0010, rs_D=5. Response: 1 load stall cycle, then 2 control-stall cycles, stall_count=3.
- Parameters: LOAD_BUBBLES=3 and CTRL_BUBBLES=0. A load-use hazard gives exactly 3 stall cycles. BCOND gives 0 stall cycles.
- Wrap and disable: CNTBITS=4, 17 stall cycles gives stall_count=1. haz_en=0 during CTRL_WAIT: outputs drop immediately, the FSM is in IDLE at the next edge, and the count is unchanged.
